ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port data RAM (RAM_B) between two masters: m0 is the CPU data path
//  (MIO_BUS RAM side) and m1 is an auxiliary master (display/debug reader or DMA).
//  Uses a req/gnt handshake, sequences each access through a small FSM and returns read data
//  with a valid pulse. Sits between MIO_BUS/aux master and RAM_B, on the clk_100mhz domain.
// PARAMETERS
//  AW         10  RAM word-address width (matches ram_addr[9:0])
//  DW         32  data width
//  RD_LAT     1   RAM read latency in cycles, from address issue to valid ram_dout (>=1)
//  MAX_BURST  4   max consecutive locked m1 grants while m0 is waiting (>=1)
// PORTS
//  clk         in   1   system clock (clk_100mhz)
//  RSTN        in   1   asynchronous active-low reset
//  m0_req      in   1   m0 access request; hold, with m0_we/addr/wdata stable, until m0_gnt
//  m0_we       in   1   1=write, 0=read
//  m0_addr     in   AW  word address
//  m0_wdata    in   DW  write data
//  m0_gnt      out  1   1-cycle pulse; m0 payload has been captured
//  m0_rvalid   out  1   1-cycle pulse; m0_rdata is valid
//  m0_rdata    out  DW  read data; held until the next m0_rvalid
//  m1_req/m1_we/m1_addr/m1_wdata/m1_gnt/m1_rvalid/m1_rdata  same as m0, for master m1
//  m1_lock     in   1   m1 requests back-to-back grants (burst)
//  ram_addr    out  AW  RAM address
//  ram_din     out  DW  RAM write data
//  ram_we      out  1   RAM write enable
//  ram_dout    in   DW  RAM read data
//  busy        out  1   FSM not in IDLE
//  owner       out  1   master owning the current access (0=m0, 1=m1)
// BEHAVIOUR
//  Reset (RSTN=0, async): all outputs 0, FSM=IDLE, burst_cnt=0, last_owner=1.
//   Mid-access reset aborts the access: ram_we drops immediately, and no gnt/rvalid is issued.
//  FSM states:
//   - IDLE: samples req at each edge. If any req is set: register ram_addr/din/we from the
//     winner, set gnt of winner=1 and owner, then go to ISSUE.
//   - ISSUE: 1 cycle; ram_* valid, gnt high. Write -> IDLE (ram_we=1 this cycle only).
//     Read -> WAIT.
//   - WAIT: RD_LAT cycles, then capture ram_dout into the winner's rdata and pulse its
//     rvalid for 1 cycle on return to IDLE.
//  Throughput: write = 2 cycles per access; read = 2+RD_LAT cycles from sampling req to rvalid.
//  Req is not sampled in ISSUE/WAIT. A req still high in the cycle after gnt is a new request.
//  Arbitration (IDLE, both req): default is fixed priority, m0 wins.
//  Lock: if m1 was last granted, m1_lock=1, m1_req=1 and burst_cnt<MAX_BURST, m1 wins
//   regardless of m0; burst_cnt increments on each locked m1 grant. On reaching MAX_BURST,
//   m0 (if requesting) wins once. burst_cnt clears on any m0 grant or when m1_lock=0.
//   Lock has no effect if m0_req=0.
//  ram_we is 0 outside ISSUE; ram_addr/ram_din hold their last value.
//  Addresses are AW bits, so there is no range check. Ordering is strict: an access completes
//   at RAM before the next is sampled, so a write followed by a read of the same address
//   returns the new data.
//  busy=1 in ISSUE and WAIT.
// CONFIGURATION
//  RAM_ARB_ROUND_ROBIN_EN defined: on conflict with no active lock, the master !=last_owner
//   wins (alternation). last_owner updates on every grant.
//  Not defined: fixed m0 priority; last_owner is used only for the lock rule.
// TESTING
//  1 RSTN=0 for 3 cycles, random inputs -> all outputs 0, busy=0; after release, first conflict
//    goes to m0.
//  2 m0 write addr 0x010 data 0xDEADBEEF, then m0 read 0x010 -> m0_gnt pulse, one ram_we cycle
//    with ram_addr=0x010; m0_rvalid 2+RD_LAT cycles after read req sampled, m0_rdata=0xDEADBEEF.
//  3 m0 read 0x004 and m1 read 0x008 held every cycle, 4 grants -> fixed: m0,m0,m0,m0 with m1
//    starved; RR_EN: m0,m1,m0,m1 with rdata routed to the correct master.
//  4 MAX_BURST=4, m1_lock=1 with 6 m1 writes, m0 read pending -> grants m1 x4, m0 x1, m1 x2;
//    burst_cnt restarts at 0.
//  5 m1 read in WAIT, RSTN pulsed low 1 cycle -> no m1_rvalid, ram_we=0, busy=0; next m1_req
//    served normally.
//  6 m1 write 0x020=0x12345678 then m0 read 0x020, requests overlapping -> m0_rdata=0x12345678,
//    with no ram_we and rvalid active in the same cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-master req/gnt arbiter for the single-port data RAM, with m1 burst locking.
// Define RAM_ARB_ROUND_ROBIN_EN to alternate unlocked conflicts instead of fixed m0 priority.
module ram_port_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    input  logic          m1_lock,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int BCW = $clog2(MAX_BURST + 1);

    state_e          state_q, state_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            we_q, we_d;
    logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic            rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [BCW-1:0]  burst_q, burst_d;
    logic            lock_act, pick1;

    // Lock only matters when m0 is actually competing; it never blocks m0 forever.
    always_comb begin
        lock_act = last_q && m1_lock && m1_req && m0_req && (burst_q < BCW'(MAX_BURST));
        if (lock_act) begin
            pick1 = 1'b1;
        end else if (m0_req && m1_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            pick1 = ~last_q;
`else
            pick1 = 1'b0;
`endif
        end else begin
            pick1 = m1_req;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_d     = 1'b0;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        rv0_d    = 1'b0;
        rv1_d    = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        owner_d  = owner_q;
        last_d   = last_q;
        burst_d  = m1_lock ? burst_q : '0;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = S_ISSUE;
                    owner_d = pick1;
                    last_d  = pick1;
                    addr_d  = pick1 ? m1_addr  : m0_addr;
                    din_d   = pick1 ? m1_wdata : m0_wdata;
                    we_d    = pick1 ? m1_we    : m0_we;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    if (!pick1) begin
                        burst_d = '0;
                    end else if (lock_act) begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = we_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == WCW'(RD_LAT - 1)) begin
                    state_d = S_IDLE;
                    if (owner_q) begin
                        rv1_d    = 1'b1;
                        rdata1_d = ram_dout;
                    end else begin
                        rv0_d    = 1'b1;
                        rdata0_d = ram_dout;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            we_q     <= we_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
        end
    end

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;
    assign ram_we    = we_q;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a transaction-level model.
module tb_ram_port_arbiter;
    localparam int AW = 10, DW = 32, RD_LAT = 2, MAX_BURST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic RSTN;
    logic m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic ram_we, busy, owner;

    ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .RSTN(RSTN),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_lock(m1_lock),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .busy(busy), .owner(owner)
    );

    function automatic logic [DW-1:0] init_word(int i);
        return 32'hA5000000 ^ (i * 32'h00010203);
    endfunction

    // Synchronous RAM with RD_LAT-stage read pipeline
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] pipe [0:RD_LAT-1];
    logic init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_dout = pipe[RD_LAT-1];

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; logic lock; } txn_t;
    txn_t q0[$], q1[$];
    int glog[$];

    int unsigned n_checks = 0, n_fail = 0;
    int cyc = 0;

    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    int next_sample, burst, p_g;
    bit last_own, have_p, p_w, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data, p_rd;
    logic [DW-1:0] exp_rdata [2];
    int we_cnt, last_we_addr, last_gnt_cyc, last_rv_cyc;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        have_p = 0; next_sample = 0; last_own = 1; burst = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        q0.delete(); q1.delete();
    endtask

    // Arbitration decision for the edge about to happen, from the currently driven requests
    task automatic model_edge(int c);
        bit w;
        if (c >= next_sample && (m0_req || m1_req)) begin
            if (m0_req && m1_req) begin
                if (last_own && m1_lock && burst < MAX_BURST) begin
                    w = 1; burst++;
                end else begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    w = !last_own;
`else
                    w = 0;
`endif
                end
            end else begin
                w = m1_req;
            end
            if (!w) burst = 0;
            last_own = w;
            have_p = 1; p_g = c; p_w = w;
            p_we   = w ? m1_we : m0_we;
            p_addr = w ? m1_addr : m0_addr;
            p_data = w ? m1_wdata : m0_wdata;
            if (p_we) begin
                model_mem[p_addr] = p_data;
                next_sample = c + 2;
            end else begin
                p_rd = model_mem[p_addr];
                next_sample = c + 2 + RD_LAT;
            end
        end
        if (!m1_lock) burst = 0;
    endtask

    task automatic check_outputs(int c);
        bit eg, rv, eb;
        eg = have_p && c == p_g;
        rv = have_p && !p_we && c == p_g + 1 + RD_LAT;
        eb = have_p && c >= p_g && c <= p_g + (p_we ? 0 : RD_LAT);
        if (rv) exp_rdata[p_w] = p_rd;
        check("m0_gnt", m0_gnt, eg && !p_w);
        check("m1_gnt", m1_gnt, eg && p_w);
        check("ram_we", ram_we, eg && p_we);
        check("busy", busy, eb);
        check("owner", owner, have_p ? p_w : 1'b0);
        check("ram_addr", ram_addr, have_p ? p_addr : '0);
        check("ram_din", ram_din, have_p ? p_data : '0);
        check("m0_rvalid", m0_rvalid, rv && !p_w);
        check("m1_rvalid", m1_rvalid, rv && p_w);
        check("m0_rdata", m0_rdata, exp_rdata[0]);
        check("m1_rdata", m1_rdata, exp_rdata[1]);
        check("we_rvalid_excl", ram_we && (m0_rvalid || m1_rvalid), 0);
    endtask

    task automatic drive();
        if (q0.size() != 0) begin
            m0_req = 1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].data;
        end else begin
            m0_req = 0; m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = $urandom;
        end
        if (q1.size() != 0) begin
            m1_req = 1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].data;
            m1_lock = q1[0].lock;
        end else begin
            m1_req = 0; m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = $urandom;
            m1_lock = 0;
        end
    endtask

    task automatic step();
        model_edge(cyc + 1);
        @(posedge clk);
        cyc++;
        #1;
        check_outputs(cyc);
        if (m0_gnt) begin glog.push_back(0); last_gnt_cyc = cyc; end
        if (m1_gnt) begin glog.push_back(1); last_gnt_cyc = cyc; end
        if (m0_rvalid || m1_rvalid) last_rv_cyc = cyc;
        if (ram_we) begin we_cnt++; last_we_addr = int'(ram_addr); end
        if (have_p && p_g == cyc) begin
            if (p_w) begin if (q1.size() != 0) void'(q1.pop_front()); end
            else begin if (q0.size() != 0) void'(q0.pop_front()); end
        end
        drive();
    endtask

    task automatic run_until_idle();
        int budget = 300;
        while ((q0.size() != 0 || q1.size() != 0 || cyc < next_sample) && budget > 0) begin
            step();
            budget--;
        end
        check("drain_timeout", budget == 0, 0);
    endtask

    task automatic chk_zero(string tag);
        check({tag, "_out"}, {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we, busy, owner}, 0);
        check({tag, "_data"}, {m0_rdata, m1_rdata}, 0);
        check({tag, "_ram"}, {ram_addr, ram_din}, 0);
    endtask

    task automatic rand_inputs();
        {m0_req, m0_we, m1_req, m1_we, m1_lock} = 5'($urandom);
        m0_addr = AW'($urandom); m1_addr = AW'($urandom);
        m0_wdata = $urandom; m1_wdata = $urandom;
    endtask

    // Called #1 after an edge; asynchronous assertion takes effect immediately
    task automatic do_reset(int n);
        RSTN = 0;
        rand_inputs();
        #1 chk_zero("rst_async");
        for (int i = 0; i < n; i++) begin
            @(posedge clk); cyc++; #1;
            chk_zero("rst_hold");
            rand_inputs();
        end
        RSTN = 1;
        model_reset();
        drive();
    endtask

    function automatic txn_t mk(logic we, int addr, logic [DW-1:0] data, logic lock);
        txn_t t;
        t.we = we; t.addr = AW'(addr); t.data = data; t.lock = lock;
        return t;
    endfunction

    initial begin
        int exp3 [4];
        int exp4 [7];
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = init_word(i);
        RSTN = 0;
        model_reset();
        rand_inputs();
        @(posedge clk); #1;

        // 1: reset with random inputs, then first conflict goes to m0
        do_reset(3);
        glog.delete();
        q0.push_back(mk(0, 'h004, 0, 0)); q1.push_back(mk(0, 'h008, 0, 0)); drive();
        run_until_idle();
        check("t1_first_winner", glog.size() > 0 ? glog[0] : 9, 0);

        // 2: m0 write then read back, one ram_we cycle, read latency
        we_cnt = 0;
        q0.push_back(mk(1, 'h010, 32'hDEADBEEF, 0)); drive();
        run_until_idle();
        check("t2_we_cycles", we_cnt, 1);
        check("t2_we_addr", last_we_addr, 'h010);
        q0.push_back(mk(0, 'h010, 0, 0)); drive();
        run_until_idle();
        check("t2_rdata", m0_rdata, 32'hDEADBEEF);
        check("t2_latency", last_rv_cyc - (last_gnt_cyc - 1), 2 + RD_LAT);

        // 3: both masters reading continuously
        q0.push_back(mk(1, 'h004, 32'h44444444, 0)); q1.push_back(mk(1, 'h008, 32'h88888888, 0));
        drive();
        run_until_idle();
        do_reset(1);
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 'h004, 0, 0)); q1.push_back(mk(0, 'h008, 0, 0));
        end
        drive();
        run_until_idle();
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp3 = '{0, 1, 0, 1};
`else
        exp3 = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) check("t3_grant_order", i < glog.size() ? glog[i] : 9, exp3[i]);

        // 4: locked m1 burst against a pending m0 read
        do_reset(1);
        glog.delete();
        for (int i = 0; i < 6; i++) q1.push_back(mk(1, 'h030 + i, $urandom, 1));
        q0.push_back(mk(0, 'h030, 0, 0));
        drive();
        run_until_idle();
        exp4 = '{1, 1, 1, 1, 0, 1, 1};
        check("t4_grant_count", glog.size(), 7);
        for (int i = 0; i < 7; i++) check("t4_grant_order", i < glog.size() ? glog[i] : 9, exp4[i]);

        // 5: reset while an m1 read is waiting on the RAM
        q1.push_back(mk(0, 'h031, 0, 0)); drive();
        begin
            int b = 20;
            while (!(have_p && p_g + 1 == cyc) && b > 0) begin step(); b--; end
            check("t5_reach_wait", b == 0, 0);
        end
        check("t5_busy_before", busy, 1);
        do_reset(1);
        for (int i = 0; i < RD_LAT + 3; i++) step();
        q1.push_back(mk(0, 'h031, 0, 0)); drive();
        run_until_idle();
        check("t5_rdata", m1_rdata, model_mem['h031]);

        // 6: m1 write followed by an overlapping m0 read of the same word
        q1.push_back(mk(1, 'h020, 32'h12345678, 0)); drive();
        step();
        q0.push_back(mk(0, 'h020, 0, 0)); drive();
        run_until_idle();
        check("t6_rdata", m0_rdata, 32'h12345678);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if (q0.size() < 3 && $urandom_range(0, 9) < 3)
                q0.push_back(mk(1'($urandom), $urandom_range(0, 15), $urandom, 0));
            if (q1.size() < 3 && $urandom_range(0, 9) < 3)
                q1.push_back(mk(1'($urandom), $urandom_range(0, 15), $urandom, 1'($urandom)));
            drive();
            step();
        end
        run_until_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
